// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bus between the pipeline front end and the PC sequencer.
//   master: pipeline side; drives current_pc, redirect, hazard and cache status, and samples the PC controls.
//   slave : sequencer side; samples the pipeline status and drives next_pc, pc_write, is_not_cache_stall,
//           flush_if_id and redirect_pending.
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] current_pc;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                hazard_stall;
    logic                icache_ready;
    logic                dcache_stall;
    logic [PC_WIDTH-1:0] next_pc;
    logic                pc_write;
    logic                is_not_cache_stall;
    logic                flush_if_id;
    logic                redirect_pending;

    modport master (
        output current_pc, redirect_valid, redirect_target, hazard_stall, icache_ready, dcache_stall,
        input  next_pc, pc_write, is_not_cache_stall, flush_if_id, redirect_pending
    );

    modport slave (
        input  current_pc, redirect_valid, redirect_target, hazard_stall, icache_ready, dcache_stall,
        output next_pc, pc_write, is_not_cache_stall, flush_if_id, redirect_pending
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC control that arbitrates boot, EX redirects, load-use and cache stalls.
//   clk   : system clock, all state updates on posedge.
//   reset : asynchronous active-low reset (0 = in reset).
//   bus   : pc_sequencer_if slave; current_pc, redirect_valid/target, hazard_stall, icache_ready and
//           dcache_stall in; next_pc, pc_write, is_not_cache_stall, flush_if_id and redirect_pending out.
//   PC_SEQ_PERF_EN (macro): adds saturating perf_stall_cycles and perf_redirects counter outputs.
module pc_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]   perf_stall_cycles,
    output logic [31:0]   perf_redirects
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, REDIR_WAIT} state_t;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pend_target, pend_nx;
    logic [PC_WIDTH-1:0] npc;
    logic                wr, flush, pend, adv, accept;

    assign adv = bus.icache_ready & ~bus.dcache_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pend_target <= '0;
        end else begin
            state       <= state_nx;
            pend_target <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pend_target;
        npc      = RESET_PC;
        wr       = 1'b0;
        flush    = 1'b0;
        pend     = 1'b0;
        accept   = 1'b0;
        unique case (state)
            BOOT: begin
                wr       = 1'b1;
                flush    = adv;
                state_nx = adv ? RUN : BOOT;
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // A redirect that cannot be taken now is parked so it survives the stall.
                    npc      = bus.redirect_target;
                    wr       = 1'b1;
                    flush    = adv;
                    accept   = adv;
                    pend_nx  = adv ? pend_target : bus.redirect_target;
                    state_nx = adv ? RUN : REDIR_WAIT;
                end else if (bus.hazard_stall) begin
                    npc = bus.current_pc;
                end else begin
                    npc = bus.current_pc + PC_WIDTH'(4);
                    wr  = 1'b1;
                end
            end
            REDIR_WAIT: begin
                // The newest redirect overrides the parked one.
                npc      = bus.redirect_valid ? bus.redirect_target : pend_target;
                pend_nx  = bus.redirect_valid ? bus.redirect_target : pend_target;
                wr       = 1'b1;
                pend     = 1'b1;
                flush    = adv;
                accept   = adv;
                state_nx = adv ? RUN : REDIR_WAIT;
            end
            default: state_nx = BOOT;
        endcase
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign bus.next_pc            = reset ? npc : RESET_PC;
    assign bus.pc_write           = reset & wr;
    assign bus.is_not_cache_stall = reset & adv;
    assign bus.flush_if_id        = reset & flush;
    assign bus.redirect_pending   = reset & pend;

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (state != BOOT && !adv && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (accept && perf_redirects != 32'hFFFF_FFFF)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; models the PC register and checks every cycle.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_WIDTH(32)) bus ();

`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_stall_cycles, perf_redirects;
    pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
    );
`else
    pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    // PC register owned by the pipeline: loads next_pc when written and advancing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.current_pc <= '0;
        else if (bus.pc_write && bus.is_not_cache_stall) bus.current_pc <= bus.next_pc;
    end

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        wr, adv, flush, pend;
        logic [31:0] pc;
        bit          perf;
        logic [31:0] ps, pr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.pc_write, bus.is_not_cache_stall, bus.flush_if_id, bus.redirect_pending, bus.current_pc}
                !== {e.npc, e.wr, e.adv, e.flush, e.pend, e.pc}) begin
                errors++;
                $display("FAIL %s: got npc=%h wr=%b adv=%b flush=%b pend=%b pc=%h, expected npc=%h wr=%b adv=%b flush=%b pend=%b pc=%h",
                         e.name, bus.next_pc, bus.pc_write, bus.is_not_cache_stall, bus.flush_if_id, bus.redirect_pending,
                         bus.current_pc, e.npc, e.wr, e.adv, e.flush, e.pend, e.pc);
            end
`ifdef PC_SEQ_PERF_EN
            if (e.perf) begin
                checks++;
                if (perf_stall_cycles !== e.ps || perf_redirects !== e.pr) begin
                    errors++;
                    $display("FAIL %s_perf: got stalls=%0d redirects=%0d, expected stalls=%0d redirects=%0d",
                             e.name, perf_stall_cycles, perf_redirects, e.ps, e.pr);
                end
            end
`endif
        end
    end

    // Drive one cycle of inputs just after the edge and queue the response expected for that cycle.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rt, input logic hz,
                        input logic ic, input logic dc, input string name, input logic [31:0] npc,
                        input logic wr, input logic adv, input logic flush, input logic pend,
                        input logic [31:0] pc, input bit perf = 0, input logic [31:0] ps = 0,
                        input logic [31:0] pr = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        bus.redirect_valid = rv;
        bus.redirect_target = rt;
        bus.hazard_stall = hz;
        bus.icache_ready = ic;
        bus.dcache_stall = dc;
        e = '{name, npc, wr, adv, flush, pend, pc, perf, ps, pr};
        sb.push_back(e);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.hazard_stall = 1'b0;
        bus.icache_ready = 1'b1;
        bus.dcache_stall = 1'b0;
        //    rst rv  target        hz ic dc  name            next_pc       wr adv fl pend pc
        step(0, 0, 32'h0,        0, 1, 0, "reset",        32'h100,      0, 0, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "boot",         32'h100,      1, 1, 1, 0, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "seq0",         32'h104,      1, 1, 0, 0, 32'h100);
        step(1, 0, 32'h0,        0, 1, 0, "seq1",         32'h108,      1, 1, 0, 0, 32'h104);
        step(1, 0, 32'h0,        1, 1, 0, "hazard",       32'h108,      0, 1, 0, 0, 32'h108);
        step(1, 0, 32'h0,        0, 1, 0, "post_hazard",  32'h10C,      1, 1, 0, 0, 32'h108);
        step(1, 1, 32'hFFFF_FFFC, 0, 1, 0, "redir_now",   32'hFFFF_FFFC, 1, 1, 1, 0, 32'h10C);
        step(1, 0, 32'h0,        0, 1, 0, "wrap",         32'h0,        1, 1, 0, 0, 32'hFFFF_FFFC);
        step(1, 1, 32'h200,      0, 0, 0, "redir_imiss",  32'h200,      1, 0, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 0, 0, "wait1",        32'h200,      1, 0, 0, 1, 32'h0);
        step(1, 0, 32'h0,        1, 0, 0, "wait2",        32'h200,      1, 0, 0, 1, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "accept200",    32'h200,      1, 1, 1, 1, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "after200",     32'h204,      1, 1, 0, 0, 32'h200);
        step(1, 1, 32'h250,      0, 1, 1, "redir_dstall", 32'h250,      1, 0, 0, 0, 32'h204);
        step(1, 1, 32'h300,      0, 1, 1, "overwrite",    32'h300,      1, 0, 0, 1, 32'h204);
        step(1, 0, 32'h0,        1, 1, 1, "pend_hold",    32'h300,      1, 0, 0, 1, 32'h204);
        step(1, 0, 32'h0,        0, 1, 0, "accept300",    32'h300,      1, 1, 1, 1, 32'h204);
        step(1, 0, 32'h0,        0, 1, 0, "after300",     32'h304,      1, 1, 0, 0, 32'h300);
        step(1, 1, 32'h400,      0, 0, 0, "redir_400",    32'h400,      1, 0, 0, 0, 32'h304);
        step(1, 0, 32'h0,        0, 0, 0, "wait400",      32'h400,      1, 0, 0, 1, 32'h304, 1, 32'd7, 32'd3);
        step(0, 0, 32'h0,        0, 0, 0, "async_reset",  32'h100,      0, 0, 0, 0, 32'h0,   1, 32'd0, 32'd0);
        step(1, 1, 32'h500,      0, 0, 0, "boot_stall",   32'h100,      1, 0, 0, 0, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "reboot",       32'h100,      1, 1, 1, 0, 32'h0);
        step(1, 0, 32'h0,        0, 1, 0, "reboot_seq",   32'h104,      1, 1, 0, 0, 32'h100, 1, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch-side control of the PC register in the 5-stage pipelined core.
- Generates next_pc, pc_write and is_not_cache_stall, and the IF/ID flush.
- Arbitrates between the boot vector, EX-stage redirects (branch/jump mispredict), load-use hazard stalls and I/D-cache stalls.
- Holds a redirect that arrives during a cache stall until the PC can accept it, so no redirect is lost.

Parameters:
- PC_WIDTH, 32, width of all PC/target buses.
- RESET_PC, 32'h0000_0000, boot vector loaded into the PC on the first cycle after reset release.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- current_pc  in  PC_WIDTH  value of the PC register.
- redirect_valid  in  1  EX stage resolved a mispredicted branch or jump this cycle.
- redirect_target  in  PC_WIDTH  correct target that accompanies redirect_valid.
- hazard_stall  in  1  load-use stall request from the hazard unit.
- icache_ready  in  1  instruction cache is returning valid data for current_pc.
- dcache_stall  in  1  data cache is busy (miss or writeback).
- next_pc  out  PC_WIDTH  value to load into the PC.
- pc_write  out  1  PC write enable.
- is_not_cache_stall  out  1  global pipeline advance qualifier.
- flush_if_id  out  1  kill the instruction in IF/ID.
- redirect_pending  out  1  a latched redirect is waiting for acceptance.

Behaviour:
- States: BOOT, RUN, REDIR_WAIT. A 2-bit state register and a PC_WIDTH pend_target register, both cleared asynchronously.
- While reset=0:
  - state=BOOT, pend_target=0.
  - Outputs forced to: next_pc=RESET_PC, pc_write=0, is_not_cache_stall=0, flush_if_id=0, redirect_pending=0.
- Combinational (reset=1): is_not_cache_stall = icache_ready & ~dcache_stall. Call this "adv". The PC updates only when pc_write & adv.
- BOOT:
  - Outputs: next_pc=RESET_PC, pc_write=1, flush_if_id=adv.
  - Transition: if adv -> RUN, else stay.
  - redirect_valid and hazard_stall are ignored.
- RUN, priority order:
  - redirect_valid & adv: next_pc=redirect_target, pc_write=1, flush_if_id=1; stay RUN.
  - redirect_valid & ~adv: pend_target<=redirect_target, go REDIR_WAIT. Outputs: next_pc=redirect_target, pc_write=1, flush_if_id=0.
  - hazard_stall: pc_write=0, next_pc=current_pc, flush_if_id=0.
  - Otherwise: next_pc=current_pc+4, pc_write=1, flush_if_id=0.
- REDIR_WAIT:
  - Outputs: redirect_pending=1, pc_write=1, hazard_stall ignored.
  - next_pc = redirect_target if redirect_valid, else pend_target.
  - If redirect_valid: pend_target<=redirect_target (newest redirect wins).
  - If adv: flush_if_id=1, go RUN. Otherwise flush_if_id=0, stay.
- Redirect latency:
  - Accepted in the same cycle it is presented if adv=1.
  - Otherwise accepted in the first cycle adv=1; the PC holds the target from the following edge.
  - flush_if_id is asserted exactly once per accepted redirect.
- Arithmetic: current_pc+4 wraps modulo 2^PC_WIDTH; target bits pass through unchanged, with no alignment check.
- Reset mid-operation: asserting reset in any state discards pend_target immediately and resumes from BOOT on release.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0], both async-cleared to 0.
  - perf_stall_cycles increments on every non-BOOT cycle with adv=0.
  - perf_redirects increments once per accepted redirect.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Boot: RESET_PC=32'h100, release reset with icache_ready=1, dcache_stall=0 -> first cycle next_pc=32'h100, pc_write=1, flush_if_id=1; next cycle next_pc=32'h104.
- Sequential fetch: current_pc=32'hFFFF_FFFC, no stalls -> next_pc=32'h0 (wrap), pc_write=1.
- Load-use: hazard_stall=1 for 1 cycle in RUN -> pc_write=0 that cycle; then next_pc=current_pc+4.
- Redirect during I-miss: icache_ready=0, redirect_valid=1 with target 32'h200 for 1 cycle, icache_ready rises 3 cycles later -> redirect_pending=1 for 3 cycles; flush_if_id=1 only in the acceptance cycle; PC=32'h200 after.
- Overwrite while pending: in REDIR_WAIT apply redirect_valid with target 32'h300 while dcache_stall=1 -> pend_target=32'h300; accepted target is 32'h300, not the earlier one.
- Async reset in REDIR_WAIT: drop reset between clock edges -> redirect_pending=0 and pc_write=0 immediately; after release the sequence restarts at RESET_PC. With PC_SEQ_PERF_EN defined, both counters read 0.
